// File: rtl/multdiv_unit.sv
// rtl/multdiv_unit.sv - iterative signed 32-bit multiplier/divider, fixed 33-cycle latency
module multdiv_unit (
    input  logic        clock,
    input  logic        clr_n,
    input  logic        ctrl_MULT,
    input  logic        ctrl_DIV,
    input  logic [31:0] data_operandA,
    input  logic [31:0] data_operandB,
    input  logic [31:0] ir_in,
    output logic [31:0] data_result,
    output logic [31:0] ir_out,
    output logic        data_exception,
    output logic        data_resultRDY,
    output logic        busy
);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t      r_state;
    logic [5:0]  r_count;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [31:0] r_opnd;
    logic        r_neg;
    logic        r_div_zero;
    logic        r_div_ovf;
    logic [31:0] r_ir;
    logic [31:0] r_result;
    logic [31:0] r_ir_out;
    logic        r_exc;
    logic        r_rdy;
    logic        r_busy;

    logic        w_accept;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic [32:0] w_mul_sum;
    logic [32:0] w_div_shift;
    logic [33:0] w_div_diff;
    logic [63:0] w_prod;
    logic        w_mul_ovf;
    logic [31:0] w_quot;
    logic        w_iter_done;

    assign w_accept    = ((r_state == S_IDLE) || (r_state == S_DONE)) && (ctrl_MULT || ctrl_DIV);
    assign w_a_mag     = data_operandA[31] ? (32'd0 - data_operandA) : data_operandA;
    assign w_b_mag     = data_operandB[31] ? (32'd0 - data_operandB) : data_operandB;
    assign w_iter_done = (r_count == 6'd32);

    // Multiply: {r_hi, r_lo} is a shift-add accumulator; r_lo starts as the multiplier magnitude.
    assign w_mul_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opnd} : 33'd0);
    assign w_prod    = r_neg ? (64'd0 - {r_hi, r_lo}) : {r_hi, r_lo};
    assign w_mul_ovf = (w_prod[63:32] != {32{w_prod[31]}});

    // Divide: restoring; r_hi is the partial remainder, r_lo shifts dividend out and quotient in.
    assign w_div_shift = {r_hi, r_lo[31]};
    assign w_div_diff  = {1'b0, w_div_shift} - {2'b00, r_opnd};
    assign w_quot      = r_neg ? (32'd0 - r_lo) : r_lo;

    always_ff @(posedge clock) begin
        if (!clr_n) begin
            r_state    <= S_IDLE;
            r_count    <= 6'd0;
            r_hi       <= 32'd0;
            r_lo       <= 32'd0;
            r_opnd     <= 32'd0;
            r_neg      <= 1'b0;
            r_div_zero <= 1'b0;
            r_div_ovf  <= 1'b0;
            r_ir       <= 32'd0;
            r_result   <= 32'd0;
            r_ir_out   <= 32'd0;
            r_exc      <= 1'b0;
            r_rdy      <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_rdy <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_accept) begin
                        r_state    <= ctrl_MULT ? S_MUL : S_DIV;
                        r_busy     <= 1'b1;
                        r_count    <= 6'd0;
                        r_hi       <= 32'd0;
                        r_lo       <= ctrl_MULT ? w_b_mag : w_a_mag;
                        r_opnd     <= ctrl_MULT ? w_a_mag : w_b_mag;
                        r_neg      <= data_operandA[31] ^ data_operandB[31];
                        r_div_zero <= (data_operandB == 32'd0);
                        r_div_ovf  <= (data_operandA == 32'h8000_0000) && (data_operandB == 32'hFFFF_FFFF);
                        r_ir       <= ir_in;
                    end else begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                S_MUL: begin
                    if (w_iter_done) begin
                        r_state  <= S_DONE;
                        r_busy   <= 1'b0;
                        r_rdy    <= 1'b1;
                        r_result <= w_prod[31:0];
                        r_exc    <= w_mul_ovf;
                        r_ir_out <= r_ir;
                    end else begin
                        r_hi    <= w_mul_sum[32:1];
                        r_lo    <= {w_mul_sum[0], r_lo[31:1]};
                        r_count <= r_count + 6'd1;
                    end
                end
                S_DIV: begin
                    if (w_iter_done) begin
                        r_state  <= S_DONE;
                        r_busy   <= 1'b0;
                        r_rdy    <= 1'b1;
                        r_result <= r_div_zero ? 32'd0 : w_quot;
                        r_exc    <= r_div_zero | r_div_ovf;
                        r_ir_out <= r_ir;
                    end else begin
                        if (!w_div_diff[33]) begin
                            r_hi <= w_div_diff[31:0];
                            r_lo <= {r_lo[30:0], 1'b1};
                        end else begin
                            r_hi <= w_div_shift[31:0];
                            r_lo <= {r_lo[30:0], 1'b0};
                        end
                        r_count <= r_count + 6'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign data_result    = r_result;
    assign ir_out         = r_ir_out;
    assign data_exception = r_exc;
    assign data_resultRDY = r_rdy;
    assign busy           = r_busy;

endmodule

// File: tb/tb_multdiv_unit.sv
// tb/tb_multdiv_unit.sv - scoreboard bench for multdiv_unit with arithmetic reference model
module tb_multdiv_unit;

    logic        clock = 1'b0;
    logic        clr_n = 1'b0;
    logic        ctrl_MULT = 1'b0;
    logic        ctrl_DIV = 1'b0;
    logic [31:0] data_operandA = 32'd0;
    logic [31:0] data_operandB = 32'd0;
    logic [31:0] ir_in = 32'd0;
    logic [31:0] data_result;
    logic [31:0] ir_out;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;

    multdiv_unit dut (
        .clock(clock), .clr_n(clr_n), .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV),
        .data_operandA(data_operandA), .data_operandB(data_operandB), .ir_in(ir_in),
        .data_result(data_result), .ir_out(ir_out), .data_exception(data_exception),
        .data_resultRDY(data_resultRDY), .busy(busy)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] res;
        logic        exc;
        logic [31:0] ir;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          cyc = 0;
    int          n_chk = 0;
    int          n_fail = 0;
    logic [31:0] h_res = 32'd0;
    logic [31:0] h_ir = 32'd0;
    logic        h_exc = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic void model(input bit is_mul, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] res, output logic exc);
        int     sa;
        int     sbv;
        int     lo;
        int     q;
        longint p;
        sa  = a;
        sbv = b;
        if (is_mul) begin
            p   = longint'(sa) * longint'(sbv);
            lo  = p[31:0];
            res = p[31:0];
            exc = (p != longint'(lo));
        end else if (b == 32'd0) begin
            res = 32'd0;
            exc = 1'b1;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            res = 32'h8000_0000;
            exc = 1'b1;
        end else begin
            q   = sa / sbv;
            res = q;
            exc = 1'b0;
        end
    endfunction

    always @(posedge clock) begin
        cyc++;
        if (!clr_n) begin
            h_res = 32'd0;
            h_ir  = 32'd0;
            h_exc = 1'b0;
        end
    end

    // Monitor: pops the scoreboard on each ready pulse; outside pulses outputs must hold.
    always @(negedge clock) begin
        exp_t e;
        if (clr_n) begin
            if (data_resultRDY) begin
                if (sb.size() == 0) begin
                    chk("spurious_ready", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("latency", cyc, e.cyc);
                    chk("result", data_result, e.res);
                    chk("exception", data_exception, e.exc);
                    chk("ir_out", ir_out, e.ir);
                    chk("busy_in_done", busy, 0);
                end
                h_res = data_result;
                h_ir  = ir_out;
                h_exc = data_exception;
            end else begin
                chk("hold_result", data_result, h_res);
                chk("hold_exception", data_exception, h_exc);
                chk("hold_ir", ir_out, h_ir);
            end
        end
    end

    task automatic issue(input bit is_mul, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] ir, input bit expect_it);
        exp_t        e;
        logic [31:0] r;
        logic        x;
        ctrl_MULT     = is_mul;
        ctrl_DIV      = !is_mul;
        data_operandA = a;
        data_operandB = b;
        ir_in         = ir;
        if (expect_it) begin
            model(is_mul, a, b, r, x);
            e.res = r;
            e.exc = x;
            e.ir  = ir;
            e.cyc = cyc + 34;
            sb.push_back(e);
        end
        @(negedge clock);
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
        ir_in         = $urandom;
        chk("busy_after_start", busy, 1);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() > 0 && n < 200) begin
            @(negedge clock);
            n++;
        end
        chk("drain_pending", sb.size(), 0);
        sb.delete();
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!data_resultRDY && n < 100) begin
            @(negedge clock);
            n++;
        end
        chk("ready_seen", data_resultRDY, 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        int          v;
        bit          m;
        repeat (3) @(negedge clock);
        chk("reset_result", data_result, 0);
        chk("reset_ir", ir_out, 0);
        chk("reset_exc", data_exception, 0);
        chk("reset_rdy", data_resultRDY, 0);
        chk("reset_busy", busy, 0);
        clr_n = 1'b1;
        @(negedge clock);

        issue(1, 32'h0000_0007, 32'hFFFF_FFFD, 32'h1234_5678, 1); drain();
        issue(1, 32'h0001_0000, 32'h0001_0000, 32'hA000_0001, 1); drain();
        issue(1, 32'h8000_0000, 32'hFFFF_FFFF, 32'hA000_0002, 1); drain();
        issue(0, 32'hFFFF_FFF9, 32'h0000_0002, 32'hA000_0003, 1); drain();
        issue(0, 32'h0000_0005, 32'h0000_0000, 32'hA000_0004, 1); drain();
        issue(0, 32'h8000_0000, 32'hFFFF_FFFF, 32'hA000_0005, 1); drain();
        @(negedge clock);

        // A divide start mid-multiply must be ignored.
        issue(1, 32'h0000_1234, 32'hFFFF_0010, 32'hB000_0001, 1);
        repeat (8) @(negedge clock);
        ctrl_DIV      = 1'b1;
        data_operandA = 32'h0000_0064;
        data_operandB = 32'h0000_0003;
        ir_in         = 32'hDEAD_BEEF;
        @(negedge clock);
        ctrl_DIV = 1'b0;
        drain();
        repeat (40) @(negedge clock);

        // Reset mid-operation aborts without a ready pulse.
        issue(1, 32'h0000_0321, 32'h0000_0777, 32'hC000_0001, 0);
        repeat (10) @(negedge clock);
        clr_n = 1'b0;
        @(negedge clock);
        clr_n = 1'b1;
        chk("abort_result", data_result, 0);
        chk("abort_ir", ir_out, 0);
        chk("abort_exc", data_exception, 0);
        chk("abort_busy", busy, 0);
        repeat (40) @(negedge clock);

        // Reset wins over a simultaneous start.
        ctrl_MULT = 1'b1;
        clr_n     = 1'b0;
        @(negedge clock);
        ctrl_MULT = 1'b0;
        clr_n     = 1'b1;
        chk("reset_vs_start_busy", busy, 0);
        @(negedge clock);
        chk("reset_vs_start_busy2", busy, 0);

        // Back-to-back: second start sampled while in DONE.
        issue(1, 32'hFFFF_FF00, 32'h0000_0100, 32'hD000_0001, 1);
        wait_ready();
        issue(0, 32'h7FFF_FFFF, 32'hFFFF_FFF0, 32'hD000_0002, 1);
        drain();

        for (int i = 0; i < 40; i++) begin
            m = $urandom_range(0, 1);
            case ($urandom_range(0, 3))
                0: begin a = $urandom; b = $urandom; end
                1: begin
                    v = $urandom_range(0, 200) - 100; a = v;
                    v = $urandom_range(0, 200) - 100; b = v;
                end
                2: begin a = $urandom; b = 32'd0; end
                default: begin a = 32'h8000_0000; b = $urandom_range(0, 1) ? 32'hFFFF_FFFF : $urandom; end
            endcase
            issue(m, a, b, $urandom, 1);
            drain();
            if ($urandom_range(0, 1)) @(negedge clock);
        end

        drain();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
